// File: rtl/axi_lite_pkg.sv
// Shared response codes, read-FSM state encoding and a constant clog2 helper
// for the AXI4-Lite to local-bus bridge.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } rd_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_rd_fsm.sv
// Read side of the bridge: AR acceptance, local read strobe, bounded wait for
// read data with SLVERR on timeout, and the R channel response register.
module axi_lite_rd_fsm
  import axi_lite_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned WIN     = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           arvalid,
  output logic           arready,
  input  logic           ar_in_win,
  input  logic [WIN-1:0] ar_offset,
  output logic [DW-1:0]  rdata,
  output logic [1:0]     rresp,
  output logic           rvalid,
  input  logic           rready,
  output logic           rd_req,
  output logic [WIN-1:0] rd_addr,
  input  logic [DW-1:0]  rd_data,
  input  logic           rd_dval
);

  localparam int unsigned TW  = clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  rd_state_t     state, state_n;
  logic [TW-1:0] timer;
  logic          ar_hs;
  logic          timer_done;

  assign ar_hs      = arvalid && arready;
  assign timer_done = (timer + 1'b1) == TMO;
  assign rd_req     = (state == RD_REQ);
  assign rvalid     = (state == RD_RESP);

  always_comb begin
    state_n = state;
    unique case (state)
      RD_IDLE: if (ar_hs) state_n = ar_in_win ? RD_REQ : RD_RESP;
      RD_REQ:  state_n = RD_WAIT;
      RD_WAIT: if (rd_dval || timer_done) state_n = RD_RESP;
      RD_RESP: if (rready) state_n = RD_IDLE;
      default: state_n = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RD_IDLE;
      arready <= 1'b0;
      timer   <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rd_addr <= '0;
    end else begin
      state   <= state_n;
      arready <= (state_n == RD_IDLE);
      unique case (state)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_addr <= ar_offset;
            if (!ar_in_win) begin
              rdata <= '0;
              rresp <= RESP_DECERR;
            end
          end
        end
        RD_REQ: timer <= '0;
        RD_WAIT: begin
          // data arriving on the expiry cycle takes priority over the timeout
          if (!timer_done) timer <= timer + 1'b1;
          if (rd_dval) begin
            rdata <= rd_data;
            rresp <= RESP_OKAY;
          end else if (timer_done) begin
            rdata <= '0;
            rresp <= RESP_SLVERR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_lbus_bridge.sv
// AXI4-Lite slave to local-bus bridge: independent AW/W holders, window decode
// with DECERR, one-cycle local write strobe; reads handled by axi_lite_rd_fsm.
module axi_lite_lbus_bridge
  import axi_lite_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int unsigned C_WIN_BITS   = 12,
  parameter int unsigned C_RD_TIMEOUT = 255
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            o_wr_req,
  output logic [C_WIN_BITS-1:0]           o_wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   o_wr_data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] o_wr_strb,
  output logic                            o_rd_req,
  output logic [C_WIN_BITS-1:0]           o_rd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   i_rd_data,
  input  logic                            i_rd_dval
);

  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW       = DW / 8;
  localparam int unsigned ADDR_LSB = clog2(SW);
  localparam logic [C_WIN_BITS-1:0] OFS_MASK =
    {{(C_WIN_BITS - ADDR_LSB){1'b1}}, {ADDR_LSB{1'b0}}};
  localparam logic [AW-C_WIN_BITS-1:0] BASE_HI = C_BASE_ADDR[AW-1:C_WIN_BITS];

  logic          aw_full, aw_full_n;
  logic          w_full, w_full_n;
  logic          bvalid_n;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  logic          aw_hs, w_hs, wr_fire, aw_in_win;
  logic          unused_prot;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
  assign wr_fire   = aw_full && w_full && !S_AXI_BVALID;
  assign aw_in_win = (aw_addr_q[AW-1:C_WIN_BITS] == BASE_HI);

  // ready flags are registered copies of "holder empty and no B pending",
  // so they can never be high while the matching holder is occupied
  always_comb begin
    aw_full_n = aw_full;
    w_full_n  = w_full;
    bvalid_n  = S_AXI_BVALID;
    if (aw_hs) aw_full_n = 1'b1;
    if (w_hs)  w_full_n  = 1'b1;
    if (wr_fire) begin
      aw_full_n = 1'b0;
      w_full_n  = 1'b0;
      bvalid_n  = 1'b1;
    end else if (S_AXI_BVALID && S_AXI_BREADY) begin
      bvalid_n = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      o_wr_req      <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_wr_strb     <= '0;
    end else begin
      aw_full       <= aw_full_n;
      w_full        <= w_full_n;
      S_AXI_BVALID  <= bvalid_n;
      S_AXI_AWREADY <= !aw_full_n && !bvalid_n;
      S_AXI_WREADY  <= !w_full_n && !bvalid_n;
      o_wr_req      <= wr_fire && aw_in_win && (|w_strb_q);
      if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (wr_fire) begin
        S_AXI_BRESP <= aw_in_win ? RESP_OKAY : RESP_DECERR;
        o_wr_addr   <= aw_addr_q[C_WIN_BITS-1:0] & OFS_MASK;
        o_wr_data   <= w_data_q;
        o_wr_strb   <= w_strb_q;
      end
    end
  end

  axi_lite_rd_fsm #(
    .DW      (DW),
    .WIN     (C_WIN_BITS),
    .TIMEOUT (C_RD_TIMEOUT)
  ) u_rd_fsm (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .arvalid   (S_AXI_ARVALID),
    .arready   (S_AXI_ARREADY),
    .ar_in_win (S_AXI_ARADDR[AW-1:C_WIN_BITS] == BASE_HI),
    .ar_offset (S_AXI_ARADDR[C_WIN_BITS-1:0] & OFS_MASK),
    .rdata     (S_AXI_RDATA),
    .rresp     (S_AXI_RRESP),
    .rvalid    (S_AXI_RVALID),
    .rready    (S_AXI_RREADY),
    .rd_req    (o_rd_req),
    .rd_addr   (o_rd_addr),
    .rd_data   (i_rd_data),
    .rd_dval   (i_rd_dval)
  );

endmodule

// File: tb/tb_axi_lite_lbus_bridge.sv
// Directed bench for axi_lite_lbus_bridge: a vector table of single
// transactions plus hand-written sequences for ordering, back-pressure,
// read timeout and mid-transaction reset.
module tb_axi_lite_lbus_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata, wr_data, rd_data;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb, wr_strb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic        wr_req, rd_req, rd_dval;
  logic [11:0] wr_addr, rd_addr;

  int n_vec = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  always #5 clk = ~clk;

  axi_lite_lbus_bridge #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (32),
    .C_BASE_ADDR        (32'h4000_0000),
    .C_WIN_BITS         (12),
    .C_RD_TIMEOUT       (8)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .o_wr_req      (wr_req),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_wr_strb     (wr_strb),
    .o_rd_req      (rd_req),
    .o_rd_addr     (rd_addr),
    .i_rd_data     (rd_data),
    .i_rd_dval     (rd_dval)
  );

  always @(negedge clk) begin
    if (wr_req) wr_cnt++;
    if (rd_req) rd_cnt++;
  end

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          dly;
    bit          exp_strobe;
    logic [11:0] exp_laddr;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic aw_w_send(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output bit ok);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      bit ha, hw;
      ha = awvalid && awready;
      hw = wvalid && wready;
      tick();
      if (ha) awvalid = 1'b0;
      if (hw) wvalid = 1'b0;
    end
    ok = !(awvalid || wvalid);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] a, output bit ok);
    awaddr = a; awvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bit h;
      h = awready;
      tick();
      if (h) begin ok = 1'b1; break; end
    end
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, output bit ok);
    wdata = d; wstrb = s; wvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bit h;
      h = wready;
      tick();
      if (h) begin ok = 1'b1; break; end
    end
    wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, output bit ok);
    araddr = a; arvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bit h;
      h = arready;
      tick();
      if (h) begin ok = 1'b1; break; end
    end
    arvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] r, output bit ok);
    bready = 1'b1; ok = 1'b0; r = 2'bxx;
    for (int i = 0; i < 30; i++) begin
      if (bvalid) begin r = bresp; ok = 1'b1; tick(); break; end
      tick();
    end
  endtask

  task automatic wait_r(output logic [31:0] d, output logic [1:0] r, output bit ok);
    rready = 1'b1; ok = 1'b0; d = 'x; r = 2'bxx;
    for (int i = 0; i < 30; i++) begin
      if (rvalid) begin d = rdata; r = rresp; ok = 1'b1; tick(); break; end
      tick();
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          w0, r0;
    bit          ok;
    logic [1:0]  resp;
    logic [31:0] d;
    w0 = wr_cnt; r0 = rd_cnt;
    if (v.is_wr) begin
      aw_w_send(v.addr, v.data, v.strb, ok);
      chk($sformatf("v%0d_accept", idx), 64'(ok), 64'd1);
      wait_b(resp, ok);
      chk($sformatf("v%0d_bvalid", idx), 64'(ok), 64'd1);
      chk($sformatf("v%0d_wr_strobes", idx), 64'(wr_cnt - w0), 64'(v.exp_strobe));
      if (v.exp_strobe) begin
        chk($sformatf("v%0d_wr_addr", idx), 64'(wr_addr), 64'(v.exp_laddr));
        chk($sformatf("v%0d_wr_data", idx), 64'(wr_data), 64'(v.data));
        chk($sformatf("v%0d_wr_strb", idx), 64'(wr_strb), 64'(v.strb));
      end
      chk($sformatf("v%0d_bresp", idx), 64'(resp), 64'(v.exp_resp));
    end else begin
      ar_send(v.addr, ok);
      chk($sformatf("v%0d_ar_accept", idx), 64'(ok), 64'd1);
      if (v.exp_strobe) begin
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
          if (rd_req) begin ok = 1'b1; break; end
          tick();
        end
        chk($sformatf("v%0d_rd_req_seen", idx), 64'(ok), 64'd1);
        repeat (v.dly) tick();
        rd_data = v.data; rd_dval = 1'b1;
        tick();
        rd_dval = 1'b0; rd_data = '0;
      end
      wait_r(d, resp, ok);
      chk($sformatf("v%0d_rvalid", idx), 64'(ok), 64'd1);
      chk($sformatf("v%0d_rd_strobes", idx), 64'(rd_cnt - r0), 64'(v.exp_strobe));
      if (v.exp_strobe) chk($sformatf("v%0d_rd_addr", idx), 64'(rd_addr), 64'(v.exp_laddr));
      chk($sformatf("v%0d_rdata", idx), 64'(d), 64'(v.exp_rdata));
      chk($sformatf("v%0d_rresp", idx), 64'(resp), 64'(v.exp_resp));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          w0;
    bit          ok, hold_ok, quiet;
    logic [1:0]  resp;
    logic [31:0] d;

    //        wr  addr           data           strb  dly stb laddr   resp   rdata
    vt[0] = '{1, 32'h4000_0014, 32'hA5A5_1234, 4'b0011, 0, 1, 12'h014, 2'b00, 32'h0};
    vt[1] = '{1, 32'h4000_0FFE, 32'hDEAD_BEEF, 4'b1111, 0, 1, 12'hFFC, 2'b00, 32'h0};
    vt[2] = '{1, 32'h4000_1000, 32'h1111_1111, 4'b1111, 0, 0, 12'h000, 2'b11, 32'h0};
    vt[3] = '{1, 32'h4000_0008, 32'h2222_2222, 4'b0000, 0, 0, 12'h000, 2'b00, 32'h0};
    vt[4] = '{1, 32'h3FFF_FFFC, 32'h3333_3333, 4'b1111, 0, 0, 12'h000, 2'b11, 32'h0};
    vt[5] = '{0, 32'h4000_0020, 32'hCAFE_F00D, 4'b0000, 3, 1, 12'h020, 2'b00, 32'hCAFE_F00D};
    vt[6] = '{0, 32'h4000_0FFF, 32'h1234_5678, 4'b0000, 1, 1, 12'hFFC, 2'b00, 32'h1234_5678};
    vt[7] = '{0, 32'h4000_1000, 32'h0,         4'b0000, 0, 0, 12'h000, 2'b11, 32'h0};
    vt[8] = '{0, 32'h4000_0004, 32'h89AB_CDEF, 4'b0000, 8, 1, 12'h004, 2'b00, 32'h89AB_CDEF};
    vt[9] = '{0, 32'h3FFF_FFFC, 32'h0,         4'b0000, 0, 0, 12'h000, 2'b11, 32'h0};

    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    rd_data = '0; rd_dval = 1'b0;
    repeat (3) tick();
    chk("reset_ctrl", 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, wr_req, rd_req}), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // AW first, W three cycles later
    w0 = wr_cnt;
    aw_send(32'h4000_0014, ok);
    chk("s1_aw_accept", 64'(ok), 64'd1);
    repeat (3) tick();
    chk("s1_awready_held_low", 64'(awready), 64'd0);
    chk("s1_wready_high", 64'(wready), 64'd1);
    w_send(32'hA5A5_1234, 4'b0011, ok);
    chk("s1_w_accept", 64'(ok), 64'd1);
    chk("s1_no_early_req", 64'({wr_req, bvalid}), 64'd0);
    tick();
    chk("s1_req_and_bvalid", 64'({wr_req, bvalid}), 64'b11);
    chk("s1_wr_addr", 64'(wr_addr), 64'h014);
    chk("s1_wr_strb", 64'(wr_strb), 64'b0011);
    wait_b(resp, ok);
    chk("s1_bresp", 64'(resp), 64'd0);
    chk("s1_single_req", 64'(wr_cnt - w0), 64'd1);

    // W first, B back-pressured for five cycles
    w0 = wr_cnt;
    bready = 1'b0;
    w_send(32'h0BAD_F00D, 4'b1111, ok);
    chk("s2_w_accept", 64'(ok), 64'd1);
    tick();
    aw_send(32'h4000_0100, ok);
    chk("s2_aw_accept", 64'(ok), 64'd1);
    tick();
    hold_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!(bvalid && !awready && !wready && bresp == 2'b00)) hold_ok = 1'b0;
      tick();
    end
    chk("s2_bvalid_held", 64'(hold_ok), 64'd1);
    bready = 1'b1;
    tick();
    chk("s2_bvalid_cleared", 64'(bvalid), 64'd0);
    chk("s2_ready_after_b", 64'({awready, wready}), 64'b11);
    chk("s2_single_req", 64'(wr_cnt - w0), 64'd1);
    chk("s2_wr_data", 64'(wr_data), 64'h0BAD_F00D);

    // read timeout, late read data ignored
    rready = 1'b0;
    ar_send(32'h4000_0030, ok);
    chk("s3_ar_accept", 64'(ok), 64'd1);
    chk("s3_rd_req", 64'(rd_req), 64'd1);
    repeat (8) tick();
    chk("s3_not_early", 64'(rvalid), 64'd0);
    tick();
    chk("s3_rvalid", 64'(rvalid), 64'd1);
    chk("s3_rresp_slverr", 64'(rresp), 64'b10);
    chk("s3_rdata_zero", 64'(rdata), 64'd0);
    rd_data = 32'hFFFF_FFFF; rd_dval = 1'b1;
    tick();
    rd_dval = 1'b0;
    chk("s3_late_dval_ignored", 64'({rvalid, rresp, rdata}), {29'd0, 1'b1, 2'b10, 32'd0});
    rready = 1'b1;
    tick();
    chk("s3_rvalid_cleared", 64'(rvalid), 64'd0);
    chk("s3_arready_back", 64'(arready), 64'd1);
    rd_dval = 1'b1;
    tick();
    rd_dval = 1'b0;
    chk("s3_idle_dval_ignored", 64'(rvalid), 64'd0);

    // reset during read WAIT with an AW held
    aw_send(32'h4000_0040, ok);
    chk("s4_aw_accept", 64'(ok), 64'd1);
    ar_send(32'h4000_0044, ok);
    chk("s4_ar_accept", 64'(ok), 64'd1);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("s4_rst_ctrl", 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, wr_req, rd_req}), 64'd0);
    chk("s4_rst_addr", 64'({wr_addr, rd_addr, wr_strb}), 64'd0);
    chk("s4_rst_data", 64'({wr_data, rdata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt;
    w_send(32'h7777_7777, 4'b1111, ok);
    chk("s4_w_accept", 64'(ok), 64'd1);
    rd_dval = 1'b1;
    tick();
    rd_dval = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (bvalid || rvalid || wr_req || rd_req) quiet = 1'b0;
      tick();
    end
    chk("s4_quiet_after_reset", 64'(quiet), 64'd1);
    chk("s4_no_wr_req", 64'(wr_cnt - w0), 64'd0);
    run_vec(vt[5], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_lbus_bridge.md
Name: axi_lite_lbus_bridge

Overview:
Parametrised AXI4-Lite slave to local-bus bridge; next generation of the team's AXI-Lite register front end. Adds independent AW/W acceptance, byte-strobe forwarding, base-address window decode with DECERR, and a read-wait state machine with timeout and SLVERR. Sits between the PS/interconnect AXI-Lite master and the IP register banks (e.g. rgb_analyze control/status).

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; 32 or 64 only.
C_S_AXI_ADDR_WIDTH, 32, AXI address width.
C_BASE_ADDR, 32'h0000_0000, window base; must be aligned to 2**C_WIN_BITS.
C_WIN_BITS, 12, window size is 2**C_WIN_BITS bytes; local address width.
C_RD_TIMEOUT, 255, cycles to wait for i_rd_dval before SLVERR; 1..65535.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset, asynchronous, active-low
S_AXI_AWADDR/AWVALID/AWREADY/AWPROT, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY  AXI4-Lite write channels (standard widths; AWPROT ignored)
S_AXI_ARADDR/ARVALID/ARREADY/ARPROT, RDATA/RRESP/RVALID/RREADY  AXI4-Lite read channels (ARPROT ignored)
o_wr_req  out  1  one-cycle local write strobe
o_wr_addr  out  C_WIN_BITS  word-aligned window offset
o_wr_data  out  DW  write data
o_wr_strb  out  DW/8  byte enables
o_rd_req  out  1  one-cycle local read strobe
o_rd_addr  out  C_WIN_BITS  word-aligned window offset
i_rd_data  in  DW  read data, valid with i_rd_dval
i_rd_dval  in  1  read data valid, single-cycle

Behaviour:
- Reset: every output and state register 0 (ready signals low, BRESP/RRESP 2'b00, RDATA 0); async assert, sync-release expected from reset source. Reset mid-transaction drops it; no local strobe, no response afterwards.
- ADDR_LSB = log2(DW/8); local offsets = addr[C_WIN_BITS-1:0] with bits below ADDR_LSB forced 0. In-window: addr[AW-1:C_WIN_BITS] == C_BASE_ADDR[AW-1:C_WIN_BITS].
- Write: AW and W each have a one-entry holding register; AWREADY = AW holder empty, WREADY = W holder empty, both registered and low while BVALID is pending. Either order, same cycle, or gap of any length accepted.
- When both holders full and BVALID low: next cycle drives o_wr_req=1 for exactly one cycle with addr/data/strb, BVALID rises the same edge; holders cleared. Latency: AW+W both handshaken at edge T -> o_wr_req in cycle T+1, BVALID high from T+1.
- Out-of-window write: no o_wr_req, BRESP=2'b11 (DECERR). WSTRB all zero: no o_wr_req, BRESP OKAY. Otherwise BRESP OKAY.
- BVALID/BRESP held stable until BREADY; holders may refill only after B handshake.
- Read FSM states: IDLE, REQ, WAIT, RESP. ARREADY high only in IDLE.
  IDLE: AR handshake -> latch addr; in-window -> REQ, else -> RESP with RRESP=2'b11, RDATA=0.
  REQ: o_rd_req=1 one cycle, timer cleared -> WAIT.
  WAIT: i_rd_dval -> RESP, RDATA=i_rd_data, OKAY; timer reaches C_RD_TIMEOUT -> RESP, RDATA=0, RRESP=2'b10. i_rd_dval on the expiry cycle wins (OKAY).
  RESP: RVALID=1, RDATA/RRESP stable until RREADY -> IDLE (ARREADY high next cycle).
- i_rd_dval outside WAIT ignored. Read and write paths fully independent; simultaneous o_wr_req and o_rd_req allowed.
- Timer width = clog2(C_RD_TIMEOUT+1); no wrap, saturates at compare.

Decomposition:
- Package axi_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, read-state encoding, clog2 function.
- One sub-module axi_lite_rd_fsm (read FSM, timer, R channel); write path stays in top.

Test Plan:
- AW at cycle 0, W at cycle 3, addr C_BASE+0x14, data 0xA5A5_1234, strb 4'b0011, BREADY=1 -> o_wr_req once, o_wr_addr=0x014, strb 0011, BRESP 00.
- W before AW, BREADY held low 5 cycles -> single o_wr_req; BVALID held 5 cycles; AWREADY/WREADY low until B handshake.
- Read C_BASE+0x20, i_rd_dval with 0xCAFE_F00D 3 cycles after o_rd_req, RREADY=1 -> RDATA 0xCAFE_F00D, RRESP 00, one o_rd_req.
- Read, no i_rd_dval, C_RD_TIMEOUT=8 -> RVALID after 8 WAIT cycles, RRESP 10, RDATA 0; late i_rd_dval ignored.
- Write and read to C_BASE+0x1000 (C_WIN_BITS=12) -> no local strobes, BRESP 11, RRESP 11.
- ARESETN low during WAIT and with AW held -> all outputs 0 immediately; no o_wr_req/RVALID after release; next read completes normally.
